// File: rtl/rand_pkg.sv
// Shared definitions for the random-number scheduler: word width, reset seed, LFSR taps, FSM states.
// x^12+x^6+x^4+x+1 feedback taken from bits 11, 5, 3 and 0 of the current word.
package rand_pkg;

  localparam int RAND_WIDTH = 12;
  localparam logic [RAND_WIDTH-1:0] RAND_SEED = 12'hACE;

  localparam int TAP_HI = 11;
  localparam int TAP_A  = 5;
  localparam int TAP_B  = 3;
  localparam int TAP_C  = 0;

  typedef enum logic [1:0] {
    WARM,
    IDLE,
    GRANT
  } state_t;

  function automatic logic [RAND_WIDTH-1:0] lfsr_next(input logic [RAND_WIDTH-1:0] q);
    return {q[RAND_WIDTH-2:0], q[TAP_HI] ^ q[TAP_A] ^ q[TAP_B] ^ q[TAP_C]};
  endfunction

endpackage

// File: rtl/rand_lfsr_core.sv
// 12-bit maximal-length LFSR register; load overrides step, result visible the cycle after.
// No backpressure: the owner decides when to step or load.
module rand_lfsr_core
  import rand_pkg::*;
#(
  parameter logic [RAND_WIDTH-1:0] SEED = RAND_SEED
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  load,
  input  logic [RAND_WIDTH-1:0] load_value,
  output logic [RAND_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= SEED;
    end else if (load) begin
      q <= load_value;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/rand_scheduler.sv
// Round-robin share of one LFSR among N_REQ requesters; grant strobe one cycle after req seen in IDLE.
// At most one grant per two cycles; requesters hold req until granted, ready low outside IDLE.
module rand_scheduler
  import rand_pkg::*;
#(
  parameter int               N_REQ  = 4,
  parameter int               WIDTH  = 12,
  parameter logic [WIDTH-1:0] SEED   = 12'hACE,
  parameter int               WARMUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic [N_REQ-1:0] grant,
  output logic [WIDTH-1:0] rand_out,
  output logic             rand_valid,
  output logic             ready
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [3:0] WARM_LAST = 4'(WARMUP - 1);

  state_t           state_q, state_d;
  logic [3:0]       warm_q, warm_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [PW-1:0]    rr_win, ptr_next, cand;
  logic             found;
  int               idx, nxt_i;
  logic [WIDTH-1:0] lfsr_q, rand_q, load_value;
  logic             lfsr_step, lfsr_load, serve;

  rand_lfsr_core #(
    .SEED(SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .step      (lfsr_step),
    .load      (lfsr_load),
    .load_value(load_value),
    .q         (lfsr_q)
  );

  // An all-zero seed would lock the LFSR, so it is replaced by the reset seed.
  assign load_value = (seed_data == '0) ? SEED : seed_data;

  // Priority search starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    rr_win = ptr_q;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx  = (int'(ptr_q) + i) % N_REQ;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        rr_win = cand;
      end
    end
  end

  always_comb begin
    nxt_i    = (int'(win_q) + 1) % N_REQ;
    ptr_next = PW'(nxt_i);
  end

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    serve     = 1'b0;
    case (state_q)
      WARM: begin
        lfsr_step = 1'b1;
        if (warm_q == WARM_LAST) begin
          state_d = IDLE;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + 4'd1;
        end
      end
      IDLE: begin
        if (|req) begin
          win_d   = rr_win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        serve     = 1'b1;
        lfsr_step = 1'b1;
        ptr_d     = ptr_next;
        state_d   = IDLE;
      end
      default: state_d = WARM;
    endcase
    // Reseed wins in every state and cancels a grant already on the wire.
    if (seed_load) begin
      lfsr_load = 1'b1;
      lfsr_step = 1'b0;
      serve     = 1'b0;
      warm_d    = '0;
      ptr_d     = ptr_q;
      win_d     = win_q;
      state_d   = WARM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WARM;
      warm_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      if (state_q == IDLE) begin
        rand_q <= lfsr_q;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (serve) begin
      grant[win_q] = 1'b1;
    end
  end

  assign rand_valid = serve;
  assign rand_out   = serve ? rand_q : '0;
  assign ready      = (state_q == IDLE);

endmodule

// File: tb/tb_rand_scheduler.sv
// Randomized and directed bench for rand_scheduler against a cycle-level behavioural model.
module tb_rand_scheduler;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int WU = 4;
  localparam logic [W-1:0] SEED = 12'hACE;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         seed_load;
  logic [W-1:0] seed_data;
  logic [N-1:0] grant;
  logic [W-1:0] rand_out;
  logic         rand_valid;
  logic         ready;

  rand_scheduler #(
    .N_REQ (N),
    .WIDTH (W),
    .SEED  (SEED),
    .WARMUP(WU)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .grant     (grant),
    .rand_out  (rand_out),
    .rand_valid(rand_valid),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: remaining warm-up edges, current random word, priority pointer, winner awaiting its strobe.
  logic [W-1:0] m_lfsr;
  int           m_warm;
  int           m_p;
  int           m_gw;

  function automatic logic [W-1:0] step12(input logic [W-1:0] v);
    return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_warm = WU;
    m_p    = 0;
    m_gw   = -1;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (seed_load) begin
      m_lfsr = (seed_data == '0) ? SEED : seed_data;
      m_warm = WU;
      m_gw   = -1;
    end else if (m_warm > 0) begin
      m_lfsr = step12(m_lfsr);
      m_warm = m_warm - 1;
    end else if (m_gw >= 0) begin
      m_lfsr = step12(m_lfsr);
      m_p    = (m_gw + 1) % N;
      m_gw   = -1;
    end else if (req != '0) begin
      m_gw = pick(req, m_p);
    end
  endtask

  function automatic logic m_granting();
    return !reset && (m_gw >= 0) && !seed_load;
  endfunction

  // Expected {grant, rand_valid, rand_out, ready} for the current cycle and inputs.
  function automatic logic [N+W+1:0] expv();
    logic [N-1:0] g;
    logic [W-1:0] r;
    logic         rdy;
    g   = '0;
    r   = '0;
    rdy = !reset && (m_warm == 0) && (m_gw < 0);
    if (m_granting()) begin
      g[m_gw] = 1'b1;
      r       = m_lfsr;
    end
    return {g, m_granting(), r, rdy};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] seq [5];
    seq = '{12'hACE, 12'h59C, 12'hB39, 12'h672, 12'hCE5};
    reset = 1'b1; req = '0; seed_load = 1'b0; seed_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({grant, rand_valid, rand_out, ready} !== '0)
      $display("FAIL reset_outputs got=%h exp=0", {grant, rand_valid, rand_out, ready});
    else n_pass++;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c <= WU + 1; c++) begin
      if (c > 0) tick();
      if (c <= WU) begin
        n_checks++;
        if (u_dut.u_lfsr.q !== seq[c])
          $display("FAIL warm_seq c=%0d got=%h exp=%h", c, u_dut.u_lfsr.q, seq[c]);
        else n_pass++;
      end
      n_checks++;
      if (ready !== (c >= WU) || grant !== '0)
        $display("FAIL warm_ready c=%0d got=%b/%b exp=%b/0", c, ready, grant, c >= WU);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [W-1:0] vals [$];
    int           at [$];
    req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if ({grant, rand_valid, rand_out, ready} !== expv())
        $display("FAIL single c=%0d got=%h exp=%h", c, {grant, rand_valid, rand_out, ready}, expv());
      else n_pass++;
      if (grant !== '0) begin
        vals.push_back(rand_out);
        at.push_back(c);
      end
    end
    n_checks++;
    if (vals.size() < 2 || vals[0] !== 12'hCE5 || vals[1] !== 12'h9CB || at[1] - at[0] != 2)
      $display("FAIL single_values got n=%0d v0=%h v1=%h exp v0=ce5 v1=9cb gap=2",
               vals.size(), (vals.size() > 0) ? vals[0] : '0, (vals.size() > 1) ? vals[1] : '0);
    else n_pass++;
    req = '0;
    tick();
  endtask

  task automatic test_all_active();
    int last [N];
    int prev;
    for (int i = 0; i < N; i++) last[i] = -1;
    prev = -1;
    req  = '1;
    for (int c = 0; c < 4 * N + 1; c++) begin
      tick();
      n_checks++;
      if ({grant, rand_valid, rand_out, ready} !== expv() || !$onehot0(grant))
        $display("FAIL all c=%0d got=%h exp=%h", c, {grant, rand_valid, rand_out, ready}, expv());
      else n_pass++;
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          if (prev >= 0) begin
            n_checks++;
            if (i != (prev + 1) % N) $display("FAIL all_order got=%0d exp=%0d", i, (prev + 1) % N);
            else n_pass++;
          end
          if (last[i] >= 0) begin
            n_checks++;
            if (c - last[i] != 2 * N) $display("FAIL all_period idx=%0d got=%0d exp=%0d", i, c - last[i], 2 * N);
            else n_pass++;
          end
          last[i] = c;
          prev    = i;
        end
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    logic [N-1:0] got [$];
    logic [N-1:0] want [3];
    want = '{4'b1000, 4'b0001, 4'b1000};
    req  = 4'b0100;
    for (int c = 0; c < 10 && grant === '0; c++) tick();
    n_checks++;
    if (grant !== 4'b0100) $display("FAIL wrap_setup got=%b exp=0100", grant);
    else n_pass++;
    req = 4'b1001;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if ({grant, rand_valid, rand_out, ready} !== expv())
        $display("FAIL wrap c=%0d got=%h exp=%h", c, {grant, rand_valid, rand_out, ready}, expv());
      else n_pass++;
      if (grant !== '0) got.push_back(grant);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got.size() <= k || got[k] !== want[k])
        $display("FAIL wrap_order k=%0d got=%b exp=%b", k, (got.size() > k) ? got[k] : '0, want[k]);
      else n_pass++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_reseed();
    int k;
    req = 4'b0001;
    for (int c = 0; c < 10 && m_gw < 0; c++) tick();
    seed_load = 1'b1;
    seed_data = '0;
    #1;
    n_checks++;
    if ({grant, rand_valid, rand_out} !== '0 || {grant, rand_valid, rand_out, ready} !== expv())
      $display("FAIL reseed_suppress got=%h exp=0", {grant, rand_valid, rand_out});
    else n_pass++;
    tick();
    seed_load = 1'b0;
    n_checks++;
    if (u_dut.u_lfsr.q !== 12'hACE) $display("FAIL reseed_value got=%h exp=ace", u_dut.u_lfsr.q);
    else n_pass++;
    k = 0;
    for (int c = 1; c < 12 && k == 0; c++) begin
      tick();
      n_checks++;
      if ({grant, rand_valid, rand_out, ready} !== expv())
        $display("FAIL reseed c=%0d got=%h exp=%h", c, {grant, rand_valid, rand_out, ready}, expv());
      else n_pass++;
      if (grant !== '0) k = c;
    end
    n_checks++;
    if (k != WU + 1 || grant !== 4'b0001 || rand_out !== 12'hCE5)
      $display("FAIL reseed_grant got=%0d/%b/%h exp=%0d/0001/ce5", k, grant, rand_out, WU + 1);
    else n_pass++;
    req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    int k;
    req = 4'b1100;
    for (int c = 0; c < 10 && m_gw < 0; c++) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (grant !== '0 || rand_valid !== 1'b0 || ready !== 1'b0)
      $display("FAIL async_drop got=%b/%b/%b exp=0/0/0", grant, rand_valid, ready);
    else n_pass++;
    @(negedge clk);
    tick();
    reset = 1'b0;
    model_reset();
    req = 4'b1001;
    k = 0;
    for (int c = 1; c < 12 && k == 0; c++) begin
      tick();
      n_checks++;
      if ({grant, rand_valid, rand_out, ready} !== expv())
        $display("FAIL async c=%0d got=%h exp=%h", c, {grant, rand_valid, rand_out, ready}, expv());
      else n_pass++;
      if (grant !== '0) k = c;
    end
    n_checks++;
    if (grant !== 4'b0001 || rand_out !== 12'hCE5)
      $display("FAIL async_first got=%b/%h exp=0001/ce5", grant, rand_out);
    else n_pass++;
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pending;
    logic [N-1:0] served;
    pending = '0;
    served  = '0;
    for (int c = 0; c < 600; c++) begin
      tick();
      pending   = (pending & ~served) | (($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
      req       = pending;
      seed_load = ($urandom_range(0, 24) == 0);
      seed_data = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      #1;
      n_checks++;
      if ({grant, rand_valid, rand_out, ready} !== expv())
        $display("FAIL random c=%0d got=%h exp=%h", c, {grant, rand_valid, rand_out, ready}, expv());
      else n_pass++;
      served = '0;
      if (m_granting()) served[m_gw] = 1'b1;
    end
    seed_load = 1'b0;
    req       = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_active();
    test_wrap();
    test_reseed();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
